acq_port_scheduler: RTL
=======================

// Module: acq_port_scheduler
// PURPOSE
//   Sequences ADC samples from the 125 MHz ADC stream onto two AXIS output ports as triggered bursts.
//   Sits between the ADC interface and the two downstream consumers (DMA/FIFO), replacing a fixed split.
//   Software arms it, then each trigger edge releases a burst of cfg_len samples per the selected mode.
//   Samples are sign-extended ADC_DATA_WIDTH -> AXIS_TDATA_WIDTH. Over-runs are counted, never stalled.
// PARAMETERS
//   ADC_DATA_WIDTH    16  valid ADC bits in S_AXIS_tdata[ADC_DATA_WIDTH-1:0]
//   AXIS_TDATA_WIDTH  32  width of all AXIS tdata buses
//   CNT_WIDTH         16  width of burst-length counter and cfg_len
//   BURST_WIDTH        8  width of burst counter and cfg_bursts
// PORTS
//   aclk                 in   1                 clock, 125 MHz; the only clock
//   reset                in   1                 synchronous reset, active-high
//   S_AXIS_tdata         in   AXIS_TDATA_WIDTH  ADC sample
//   S_AXIS_tvalid        in   1                 sample valid. No tready: the source cannot stall
//   M_AXIS_PORT1_tdata   out  AXIS_TDATA_WIDTH  port 1 sample, sign-extended
//   M_AXIS_PORT1_tvalid  out  1                 port 1 valid
//   M_AXIS_PORT1_tready  in   1                 port 1 ready
//   M_AXIS_PORT2_tdata/_tvalid/_tready          as port 1, for port 2
//   cfg_start            in   1                 1-cycle pulse: latch cfg_*, IDLE->ARMED
//   cfg_stop             in   1                 1-cycle pulse: abort to FLUSH
//   cfg_mode             in   2                 00 port1, 01 port2, 10 both, 11 alternate per burst (starts port1)
//   cfg_len              in   CNT_WIDTH         samples per burst. 0 = zero-length burst, nothing forwarded
//   cfg_bursts           in   BURST_WIDTH       number of bursts. 0 = continuous until cfg_stop
//   trig                 in   1                 trigger, synchronous to aclk. Rising edge is used
//   sts_busy             out  1                 state != IDLE
//   sts_done             out  1                 1-cycle pulse on FLUSH->IDLE
//   sts_port             out  1                 active port in alternate mode (0 = port1)
//   sts_drop_cnt         out  16                dropped samples, saturating at 0xFFFF; cleared on cfg_start
// BEHAVIOUR
//   - Reset: all outputs 0, state IDLE, counters 0, trig_q 0.
//   - Trigger edge: trig_re = trig & ~trig_q. trig_q is a register.
//   - FSM IDLE -start-> ARMED -trig_re-> RUN.
//     - RUN ends after cfg_len counted samples. Then:
//       - if bursts remain (or cfg_bursts = 0): go to ARMED, and sts_port toggles in mode 11;
//       - otherwise: go to FLUSH.
//     - FLUSH -both out slots empty-> IDLE, asserting sts_done.
//     - cfg_stop in ARMED or RUN -> FLUSH on the next cycle.
//   - cfg_start outside IDLE is ignored. A trig_re outside ARMED is ignored, including one coincident with cfg_start.
//   - cfg_* values are latched on an accepted cfg_start and are constant for the whole run.
//   - In RUN, each cycle with S_AXIS_tvalid = 1 is a counted sample and increments the sample counter.
//     - cfg_len = 0: RUN exits on its first cycle.
//   - Output slot per port: one-deep register, 1-cycle latency from the sample to M tvalid.
//     - The slot clears when tvalid & tready.
//     - If the slot is full and tready = 0 when a new sample targets it:
//       - the new sample is dropped;
//       - the sample still counts toward cfg_len, so the timebase is preserved;
//       - sts_drop_cnt increments, and increments once per dropped sample in mode 10 (both ports).
//     - If tready = 1 in the same cycle, the new sample is accepted: back-to-back at 1 sample/clk.
//   - M tdata = {{(AXIS_TDATA_WIDTH-ADC_DATA_WIDTH){s[ADC_DATA_WIDTH-1]}}, s[ADC_DATA_WIDTH-1:0]}.
//   - Burst counter wraps never: when cfg_bursts = 0, the counter is not evaluated.
//   - Reset mid-run: immediate return to reset state. Slot contents are discarded and no sts_done.
// CONFIGURATION
//   ACQ_DECIM_EN
//     - Defined: adds input cfg_decim[7:0], latched on cfg_start.
//       - In RUN, only every (cfg_decim+1)-th valid sample is counted and forwarded.
//       - The decimation phase resets at each entry to RUN.
//     - Undefined: cfg_decim port is absent and every valid sample is used.
// STRUCTURE
//   acq_sched_pkg: state enum (IDLE, ARMED, RUN, FLUSH) and MODE_P1/MODE_P2/MODE_BOTH/MODE_ALT constants.
//   Sub-module acq_out_slot: one-deep AXIS register with drop detect. Instanced once per port.
// TESTING
//   - mode 00, len 4, bursts 1, tready = 1, trig edge:
//     - 4 samples on PORT1 at 1 cycle latency, PORT2 silent;
//     - sts_done 1 pulse, drop_cnt 0.
//   - mode 11, len 3, bursts 2:
//     - burst 1 -> PORT1 only, burst 2 -> PORT2 only after the 2nd trig edge;
//     - sts_port toggles 0->1.
//   - Sign extension: ADC 0x0000_8000 -> 0xFFFF_8000; 0x1234_7FFF -> 0x0000_7FFF.
//   - mode 10, len 8, PORT2 tready = 0 throughout:
//     - PORT1 gets 8 samples, PORT2 holds its 1st sample;
//     - drop_cnt = 7, FSM stays in FLUSH until PORT2 tready = 1.
//   - bursts 0, len 5: 3 trig edges give 15 samples. cfg_stop during the 3rd burst -> FLUSH -> IDLE, sts_done.
//   - reset asserted in RUN: next cycle all outputs 0, IDLE. cfg_start in RUN, and trig in IDLE, have no effect.

Source files
------------

// File: rtl/acq_sched_pkg.sv
// acq_sched_pkg: scheduler state encoding and port-mode constants
package acq_sched_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, RUN, FLUSH} state_t;

    localparam logic [1:0] MODE_P1   = 2'b00;
    localparam logic [1:0] MODE_P2   = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_ALT  = 2'b11;

endpackage

// File: rtl/acq_out_slot.sv
// acq_out_slot: one-deep AXIS output register that flags samples it must drop
module acq_out_slot #(
    parameter int W = 32
) (
    input  logic         aclk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         tready,
    output logic [W-1:0] tdata,
    output logic         tvalid,
    output logic         drop
);

    // a full slot frees itself in the same cycle it hands off, so only a stalled slot drops
    assign drop = push && tvalid && !tready;

    always_ff @(posedge aclk) begin
        if (reset) begin
            tvalid <= 1'b0;
            tdata  <= '0;
        end else if (push && !drop) begin
            tvalid <= 1'b1;
            tdata  <= din;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/acq_port_scheduler.sv
// acq_port_scheduler: trigger-released ADC bursts onto two AXIS ports; ACQ_DECIM_EN adds cfg_decim decimation
module acq_port_scheduler
    import acq_sched_pkg::*;
#(
    parameter int ADC_DATA_WIDTH   = 16,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNT_WIDTH        = 16,
    parameter int BURST_WIDTH      = 8
) (
    input  logic                        aclk,
    input  logic                        reset,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_PORT1_tdata,
    output logic                        M_AXIS_PORT1_tvalid,
    input  logic                        M_AXIS_PORT1_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_PORT2_tdata,
    output logic                        M_AXIS_PORT2_tvalid,
    input  logic                        M_AXIS_PORT2_tready,
    input  logic                        cfg_start,
    input  logic                        cfg_stop,
    input  logic [1:0]                  cfg_mode,
    input  logic [CNT_WIDTH-1:0]        cfg_len,
    input  logic [BURST_WIDTH-1:0]      cfg_bursts,
`ifdef ACQ_DECIM_EN
    input  logic [7:0]                  cfg_decim,
`endif
    input  logic                        trig,
    output logic                        sts_busy,
    output logic                        sts_done,
    output logic                        sts_port,
    output logic [15:0]                 sts_drop_cnt
);

    state_t                      state;
    logic                        trig_q, trig_re, sample, fwd, last, push1, push2, drop1, drop2;
    logic [1:0]                  mode;
    logic [CNT_WIDTH-1:0]        len, cnt;
    logic [BURST_WIDTH-1:0]      bursts, bcnt;
    logic [16:0]                 drop_sum;
    logic [AXIS_TDATA_WIDTH-1:0] sx;
    logic                        unused_hi;

    assign unused_hi = ^S_AXIS_tdata[AXIS_TDATA_WIDTH-1:ADC_DATA_WIDTH];
    assign sx = {{(AXIS_TDATA_WIDTH-ADC_DATA_WIDTH){S_AXIS_tdata[ADC_DATA_WIDTH-1]}},
                 S_AXIS_tdata[ADC_DATA_WIDTH-1:0]};
    assign trig_re = trig && !trig_q;

`ifdef ACQ_DECIM_EN
    logic [7:0] decim, dph;
    assign sample = state == RUN && S_AXIS_tvalid && dph == decim;
`else
    assign sample = state == RUN && S_AXIS_tvalid;
`endif

    // a zero-length burst still passes through RUN for one cycle but forwards nothing
    assign fwd   = sample && len != '0;
    assign last  = len == '0 || (sample && cnt == len - CNT_WIDTH'(1));
    assign push1 = fwd && (mode == MODE_P1 || mode == MODE_BOTH || (mode == MODE_ALT && !sts_port));
    assign push2 = fwd && (mode == MODE_P2 || mode == MODE_BOTH || (mode == MODE_ALT && sts_port));
    assign drop_sum = {1'b0, sts_drop_cnt} + 17'(drop1) + 17'(drop2);
    assign sts_busy = state != IDLE;

    acq_out_slot #(.W(AXIS_TDATA_WIDTH)) u_slot1 (
        .aclk(aclk), .reset(reset), .push(push1), .din(sx), .tready(M_AXIS_PORT1_tready),
        .tdata(M_AXIS_PORT1_tdata), .tvalid(M_AXIS_PORT1_tvalid), .drop(drop1)
    );

    acq_out_slot #(.W(AXIS_TDATA_WIDTH)) u_slot2 (
        .aclk(aclk), .reset(reset), .push(push2), .din(sx), .tready(M_AXIS_PORT2_tready),
        .tdata(M_AXIS_PORT2_tdata), .tvalid(M_AXIS_PORT2_tvalid), .drop(drop2)
    );

    always_ff @(posedge aclk) begin
        if (reset) begin
            state        <= IDLE;
            trig_q       <= 1'b0;
            mode         <= '0;
            len          <= '0;
            bursts       <= '0;
            cnt          <= '0;
            bcnt         <= '0;
            sts_port     <= 1'b0;
            sts_done     <= 1'b0;
            sts_drop_cnt <= '0;
`ifdef ACQ_DECIM_EN
            decim        <= '0;
            dph          <= '0;
`endif
        end else begin
            trig_q       <= trig;
            sts_done     <= 1'b0;
            sts_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            case (state)
                IDLE: if (cfg_start) begin
                    state        <= ARMED;
                    mode         <= cfg_mode;
                    len          <= cfg_len;
                    bursts       <= cfg_bursts;
                    cnt          <= '0;
                    bcnt         <= '0;
                    sts_port     <= 1'b0;
                    sts_drop_cnt <= '0;
`ifdef ACQ_DECIM_EN
                    decim        <= cfg_decim;
`endif
                end
                ARMED: begin
`ifdef ACQ_DECIM_EN
                    dph <= '0;
`endif
                    if (cfg_stop) state <= FLUSH;
                    else if (trig_re) begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
                RUN: begin
`ifdef ACQ_DECIM_EN
                    if (S_AXIS_tvalid) dph <= (dph == decim) ? 8'd0 : dph + 8'd1;
`endif
                    if (sample) cnt <= cnt + CNT_WIDTH'(1);
                    if (cfg_stop) state <= FLUSH;
                    else if (last) begin
                        cnt <= '0;
                        // bursts == 0 means continuous: the burst counter is never consulted
                        if (bursts != '0) bcnt <= bcnt + BURST_WIDTH'(1);
                        if (bursts != '0 && bcnt == bursts - BURST_WIDTH'(1)) state <= FLUSH;
                        else begin
                            state <= ARMED;
                            if (mode == MODE_ALT) sts_port <= !sts_port;
                        end
                    end
                end
                FLUSH: if (!M_AXIS_PORT1_tvalid && !M_AXIS_PORT2_tvalid) begin
                    state    <= IDLE;
                    sts_done <= 1'b1;
                end
            endcase
        end
    end

endmodule
